// File: rtl/drd_rr_arb.sv
// Round-robin arbiter sharing one DDR read port among NREQ clients, one burst per grant.
// Latency: grant decided 1 cycle after request, m_req registered; cmd/addr and read data pass combinationally.
// Backpressure: clients hold c_req until their last beat; the DDR side paces via m_ack and m_vin.
//
// Ports: clk/rst (sync, active-high), enb (0 forces IDLE).
//   Client side: c_req, c_ack, c_vout, c_dout (32 bits per client), c_vin, c_din (broadcast).
//   DDR side:    m_req, m_ack, m_vout, m_dout, m_vin, m_din.
//   Status:      busy, gnt_id, err.
// Optional feature: define DRD_ARB_TIMEOUT_EN for the data-stall watchdog (err stays 0 otherwise).
module drd_rr_arb #(
  parameter int NREQ   = 4,
  parameter int GW     = 2,
  parameter int TO_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [NREQ-1:0]   c_req,
  output logic [NREQ-1:0]   c_ack,
  input  logic [NREQ-1:0]   c_vout,
  input  logic [NREQ*32-1:0] c_dout,
  output logic [NREQ-1:0]   c_vin,
  output logic [31:0]       c_din,
  output logic              m_req,
  input  logic              m_ack,
  output logic              m_vout,
  output logic [31:0]       m_dout,
  input  logic              m_vin,
  input  logic [31:0]       m_din,
  output logic              busy,
  output logic [GW-1:0]     gnt_id,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DATA} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [7:0]      len_m1_q, len_m1_d;
  logic [8:0]      beat_q, beat_d;
  logic            m_req_q, m_req_d;

  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic [GW-1:0]   gnt_nxt;
  logic            sel_req;
  logic            sel_vout;
  logic [31:0]     sel_dout;

  // Signals of the currently granted client.
  always_comb begin
    sel_req  = 1'b0;
    sel_vout = 1'b0;
    sel_dout = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == GW'(i)) begin
        sel_req  = c_req[i];
        sel_vout = c_vout[i];
        sel_dout = c_dout[32*i +: 32];
      end
    end
  end

  // Round-robin pick: lowest requester at or above rr_ptr; failing that,
  // the lowest requester overall (the wrap-around case). Loops run downward
  // so the last hit is the lowest index.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (c_req[i]) begin
        pick     = GW'(i);
        pick_vld = 1'b1;
      end
    end
    for (int i = NREQ-1; i >= 0; i--) begin
      if (c_req[i] && (GW'(i) >= rr_ptr_q)) begin
        pick = GW'(i);
      end
    end
  end

  assign gnt_nxt = (gnt_q == GW'(NREQ-1)) ? '0 : gnt_q + GW'(1);

`ifdef DRD_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYC + 1);
  logic [SW-1:0] stall_q, stall_d, stall_inc;
  logic          err_q, err_d;
`else
  logic          unused_to;
  assign unused_to = (TO_CYC != 0);
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    len_m1_d = len_m1_q;
    beat_d   = beat_q;
`ifdef DRD_ARB_TIMEOUT_EN
    stall_d   = '0;
    stall_inc = stall_q + SW'(1);
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enb && pick_vld) begin
          gnt_d   = pick;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // m_ack takes priority over a simultaneous request drop.
        if (m_ack) begin
          len_m1_d = m_dout[7:0];
          state_d  = S_ADDR;
        end else if (!sel_req) begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        beat_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (m_vin) begin
          beat_d = beat_q + 9'd1;
          if (beat_q == {1'b0, len_m1_q}) begin
            state_d  = S_IDLE;
            rr_ptr_d = gnt_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DRD_ARB_TIMEOUT_EN
    // Stall watchdog: counts idle cycles while waiting on the DDR side.
    if ((state_q == S_REQ || state_q == S_DATA) && !m_ack && !m_vin) begin
      stall_d = stall_inc;
      if (stall_inc == SW'(TO_CYC)) begin
        stall_d  = '0;
        state_d  = S_IDLE;
        rr_ptr_d = gnt_nxt;
        err_d    = 1'b1;
      end
    end
`endif
    // Disable aborts any activity and leaves the round-robin pointer alone.
    if (!enb) begin
      state_d  = S_IDLE;
      rr_ptr_d = rr_ptr_q;
    end
    m_req_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      len_m1_q <= '0;
      beat_q   <= '0;
      m_req_q  <= 1'b0;
`ifdef DRD_ARB_TIMEOUT_EN
      stall_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      len_m1_q <= len_m1_d;
      beat_q   <= beat_d;
      m_req_q  <= m_req_d;
`ifdef DRD_ARB_TIMEOUT_EN
      stall_q  <= stall_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    c_ack = '0;
    c_vin = '0;
    for (int i = 0; i < NREQ; i++) begin
      c_ack[i] = m_ack && (state_q == S_REQ)  && (gnt_q == GW'(i));
      c_vin[i] = m_vin && (state_q == S_DATA) && (gnt_q == GW'(i));
    end
  end

  assign m_vout = sel_vout && ((state_q == S_REQ) || (state_q == S_ADDR));
  assign m_dout = m_vout ? sel_dout : '0;
  assign c_din  = (|c_vin) ? m_din : '0;
  assign m_req  = m_req_q;
  assign busy   = (state_q != S_IDLE);
  assign gnt_id = gnt_q;

`ifdef DRD_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_drd_rr_arb.sv
// Directed bench for drd_rr_arb: single client, round-robin rotation, routing,
// request drop, enable/reset aborts, 256-beat burst and (optional) stall watchdog.
module tb_drd_rr_arb;

  localparam int NREQ = 4;
  localparam int GW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enb;
  logic [NREQ-1:0]   c_req;
  logic [NREQ-1:0]   c_ack;
  logic [NREQ-1:0]   c_vout;
  logic [NREQ*32-1:0] c_dout;
  logic [NREQ-1:0]   c_vin;
  logic [31:0]       c_din;
  logic              m_req;
  logic              m_ack;
  logic              m_vout;
  logic [31:0]       m_dout;
  logic              m_vin;
  logic [31:0]       m_din;
  logic              busy;
  logic [GW-1:0]     gnt_id;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drd_rr_arb #(.NREQ(NREQ), .GW(GW), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .c_req(c_req), .c_ack(c_ack), .c_vout(c_vout), .c_dout(c_dout),
    .c_vin(c_vin), .c_din(c_din),
    .m_req(m_req), .m_ack(m_ack), .m_vout(m_vout), .m_dout(m_dout),
    .m_vin(m_vin), .m_din(m_din),
    .busy(busy), .gnt_id(gnt_id), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in REQ for client exp_g; acks at once, forwards
  // cmd/addr, feeds len+1 beats and returns with the DUT back in IDLE.
  task automatic burst(input int exp_g, input logic [7:0] len);
    chk("b_gnt", 32'(gnt_id), 32'(exp_g));
    chk("b_mreq", 32'(m_req), 32'd1);
    for (int i = 0; i < NREQ; i++) c_dout[32*i +: 32] = {16'hC0DE, 4'(i), 4'h0, len};
    c_vout = '1;
    m_ack  = 1'b1;
    m_vin  = 1'b0;
    #1;
    chk("b_ack", 32'(c_ack), 32'(1) << exp_g);
    chk("b_cmd", m_dout, {16'hC0DE, 4'(exp_g), 4'h0, len});
    tick();
    m_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) c_dout[32*i +: 32] = {16'hADD0, 4'(i), 12'h123};
    #1;
    chk("b_addr", m_dout, {16'hADD0, 4'(exp_g), 12'h123});
    tick();
    c_vout = '0;
    for (int b = 0; b <= int'(len); b++) begin
      m_vin = 1'b1;
      m_din = 32'hD000_0000 | (32'(exp_g) << 16) | 32'(b);
      #1;
      chk("b_vin", 32'(c_vin), 32'(1) << exp_g);
      chk("b_din", c_din, 32'hD000_0000 | (32'(exp_g) << 16) | 32'(b));
      chk("b_busy", 32'(busy), 32'd1);
      tick();
    end
    m_vin = 1'b0;
    #1;
    chk("b_idle", 32'(busy), 32'd0);
    chk("b_mreq_fall", 32'(m_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; enb = 1'b0; c_req = '0; c_vout = '0; c_dout = '0;
    m_ack = 1'b0; m_vin = 1'b0; m_din = '0;
    tick(); tick();
    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mreq", 32'(m_req), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ack", 32'(c_ack), 32'd0);
    chk("rst_mdout", m_dout, 32'd0);

    // 1: lone client 2, len_m1=3, ack after 2 cycles
    rst = 1'b0; enb = 1'b1; c_req = 4'b0100;
    #1;
    chk("t1_mreq0", 32'(m_req), 32'd0);
    tick();
    chk("t1_mreq1", 32'(m_req), 32'd1);
    chk("t1_gnt", 32'(gnt_id), 32'd2);
    c_vout = 4'b0100; c_dout[95:64] = 32'hA000_0003;
    #1;
    chk("t1_vout", 32'(m_vout), 32'd1);
    chk("t1_cmd_early", m_dout, 32'hA000_0003);
    chk("t1_noack", 32'(c_ack), 32'd0);
    tick();
    tick();
    m_ack = 1'b1;
    #1;
    chk("t1_ack", 32'(c_ack), 32'b0100);
    chk("t1_cmd", m_dout, 32'hA000_0003);
    tick();
    m_ack = 1'b0; c_dout[95:64] = 32'h1234_5678;
    #1;
    chk("t1_addr", m_dout, 32'h1234_5678);
    chk("t1_ack_off", 32'(c_ack), 32'd0);
    tick();
    c_vout = '0;
    #1;
    chk("t1_vout_data", 32'(m_vout), 32'd0);
    for (int k = 0; k < 4; k++) begin
      m_vin = 1'b1; m_din = 32'h100 + 32'(k);
      if (k == 3) c_req = '0;
      #1;
      chk("t1_vin", 32'(c_vin), 32'b0100);
      chk("t1_din", c_din, 32'h100 + 32'(k));
      tick();
    end
    m_vin = 1'b0;
    #1;
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_mreq_fall", 32'(m_req), 32'd0);

    // 2: all requesting, len 0, order 0,1,2,3,0 with IDLE between
    rst = 1'b1; tick(); rst = 1'b0;
    c_req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      burst(n % 4, 8'd0);
      if (n == 4) c_req = '0;
      tick();
    end

    // 3: m_vin outside DATA is dropped; client 1 routing
    m_vin = 1'b1; m_din = 32'hDEAD_BEEF;
    #1;
    chk("t3_idle_vin", 32'(c_vin), 32'd0);
    chk("t3_idle_din", c_din, 32'd0);
    c_req = 4'b0010;
    tick();
    chk("t3_req_vin", 32'(c_vin), 32'd0);
    chk("t3_req_din", c_din, 32'd0);
    burst(1, 8'd2);
    c_req = '0;
    tick();

    // 4: request dropped in REQ before ack (rr_ptr=2 -> wraps to client 0)
    c_req = 4'b0001;
    tick();
    chk("t4_gnt", 32'(gnt_id), 32'd0);
    chk("t4_mreq", 32'(m_req), 32'd1);
    c_req = '0;
    #1;
    chk("t4_noack", 32'(c_ack), 32'd0);
    tick();
    chk("t4_mreq_off", 32'(m_req), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: enb=0 at beat 2 of an 8-beat burst, then reset mid-REQ
    c_req = 4'b1000;
    tick();
    chk("t5_gnt", 32'(gnt_id), 32'd3);
    c_vout = 4'b1000; c_dout[127:96] = 32'h5000_0007; m_ack = 1'b1;
    #1;
    chk("t5_ack", 32'(c_ack), 32'b1000);
    tick();
    m_ack = 1'b0;
    tick();
    c_vout = '0; m_vin = 1'b1; m_din = 32'd1;
    #1;
    chk("t5_beat1", 32'(c_vin), 32'b1000);
    tick();
    m_din = 32'd2;
    #1;
    chk("t5_beat2", 32'(c_vin), 32'b1000);
    enb = 1'b0;
    tick();
    chk("t5_busy_off", 32'(busy), 32'd0);
    chk("t5_mreq_off", 32'(m_req), 32'd0);
    chk("t5_drop3", 32'(c_vin), 32'd0);
    tick();
    chk("t5_drop4", 32'(c_vin), 32'd0);
    // rr_ptr must still be 2: requesters {0,3} -> 3
    m_vin = 1'b0; enb = 1'b1; c_req = 4'b1001;
    tick();
    chk("t5_rr_kept", 32'(gnt_id), 32'd3);
    rst = 1'b1; m_ack = 1'b1; m_vin = 1'b1; c_vout = '1;
    tick();
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_mreq", 32'(m_req), 32'd0);
    chk("t5_rst_gnt", 32'(gnt_id), 32'd0);
    chk("t5_rst_ack", 32'(c_ack), 32'd0);
    chk("t5_rst_vin", 32'(c_vin), 32'd0);
    chk("t5_rst_vout", 32'(m_vout), 32'd0);
    chk("t5_rst_din", c_din, 32'd0);
    rst = 1'b0; m_ack = 1'b0; m_vin = 1'b0; c_vout = '0; c_req = '0;
    tick();

    // 256-beat burst (len_m1=255)
    c_req = 4'b0001;
    tick();
    burst(0, 8'hFF);
    c_req = '0;
    tick();

`ifdef DRD_ARB_TIMEOUT_EN
    // 6: data stall of 16 cycles aborts, sets err, next grant moves on
    rst = 1'b1; tick(); rst = 1'b0;
    c_req = 4'b0011;
    tick();
    chk("t6_gnt0", 32'(gnt_id), 32'd0);
    c_vout = 4'b0001; c_dout[31:0] = 32'h0000_0003; m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    c_vout = '0;
    for (int s = 0; s < 15; s++) tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_err_pre", 32'(err), 32'd0);
    tick();
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_next_gnt", 32'(gnt_id), 32'd1);
    chk("t6_err_sticky", 32'(err), 32'd1);
    c_req = '0;
    tick();
`else
    chk("t6_err_tied", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
